// File: rtl/fetch_queue.sv
// Fetch-to-decode instruction buffer: a DEPTH-entry circular FIFO of {pc, inst} pairs with a one-cycle flush.
// Optional feature macro IFQ_BYPASS_EN adds a zero-latency path from fetch to decode when the queue is empty.
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       redir_i,
  input  logic                       in_valid_i,
  input  logic [XLEN-1:0]            in_pc_i,
  input  logic [XLEN-1:0]            in_inst_i,
  output logic                       in_ready_o,
  output logic                       out_valid_o,
  output logic [XLEN-1:0]            out_pc_o,
  output logic [XLEN-1:0]            out_inst_o,
  input  logic                       out_ready_i,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [XLEN-1:0] pc_mem   [DEPTH];
  logic [XLEN-1:0] inst_mem [DEPTH];

  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;

  logic full;
  logic empty;
  logic bypass;
  logic enq;
  logic deq;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

`ifdef IFQ_BYPASS_EN
  // An empty queue with decode ready hands the fetch word straight through.
  assign bypass = rst_ni && empty && in_valid_i && out_ready_i && !redir_i;
`else
  assign bypass = 1'b0;
`endif

  assign in_ready_o  = rst_ni && !full;
  assign out_valid_o = rst_ni && !redir_i && (!empty || bypass);

  // A bypassed word is consumed directly and touches neither storage nor count.
  assign enq = in_valid_i && in_ready_o && !redir_i && !bypass;
  assign deq = out_valid_o && out_ready_i && !bypass;

  always_comb begin
    out_pc_o   = '0;
    out_inst_o = '0;
    if (out_valid_o) begin
      if (bypass) begin
        out_pc_o   = in_pc_i;
        out_inst_o = in_inst_i;
      end else begin
        out_pc_o   = pc_mem[rd_ptr_q];
        out_inst_o = inst_mem[rd_ptr_q];
      end
    end
  end

  assign count_o = rst_ni ? count_q : '0;

  always_ff @(posedge clk_i) begin
    if (enq) begin
      pc_mem[wr_ptr_q]   <= in_pc_i;
      inst_mem[wr_ptr_q] <= in_inst_i;
    end
  end

  // Reset outranks flush, and flush outranks any handshake in the same cycle.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (redir_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (enq) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (deq) rd_ptr_q <= rd_ptr_q + PW'(1);
      if (enq && !deq)      count_q <= count_q + CW'(1);
      else if (deq && !enq) count_q <= count_q - CW'(1);
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed scenarios plus random traffic against a queue-based model.
module tb_fetch_queue;
  localparam int DEPTH = 4;
  localparam int XLEN  = 32;
  localparam int CW    = $clog2(DEPTH+1);
  localparam int OW    = 2*XLEN + CW + 2;
`ifdef IFQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic redir = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic [XLEN-1:0] in_pc = '0;
  logic [XLEN-1:0] in_inst = '0;
  logic in_ready, out_valid;
  logic [XLEN-1:0] out_pc, out_inst;
  logic [CW-1:0] count;

  fetch_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk_i(clk), .rst_ni(rst_n), .redir_i(redir),
    .in_valid_i(in_valid), .in_pc_i(in_pc), .in_inst_i(in_inst), .in_ready_o(in_ready),
    .out_valid_o(out_valid), .out_pc_o(out_pc), .out_inst_o(out_inst),
    .out_ready_i(out_ready), .count_o(count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass = 0;

  // Reference model: the queue contents as a plain list of {pc, inst}.
  logic [2*XLEN-1:0] mq[$];
  logic exp_byp, exp_ready, exp_valid;
  logic [XLEN-1:0] exp_pc, exp_inst;
  logic [CW-1:0] exp_count;
  logic [OW-1:0] exp_obs;
  wire  [OW-1:0] obs = {in_ready, out_valid, out_pc, out_inst, count};

  task automatic eval_model();
    exp_byp   = BYP && rst_n && (mq.size() == 0) && in_valid && out_ready && !redir;
    exp_ready = rst_n && (mq.size() < DEPTH);
    exp_valid = rst_n && !redir && (mq.size() != 0 || exp_byp);
    exp_pc = '0;
    exp_inst = '0;
    if (exp_valid) begin
      if (exp_byp) {exp_pc, exp_inst} = {in_pc, in_inst};
      else         {exp_pc, exp_inst} = mq[0];
    end
    exp_count = rst_n ? CW'(mq.size()) : '0;
    exp_obs = {exp_ready, exp_valid, exp_pc, exp_inst, exp_count};
  endtask

  task automatic apply(input logic r, input logic rd, input logic iv,
                       input logic [XLEN-1:0] pc, input logic [XLEN-1:0] inst, input logic ordy);
    @(negedge clk);
    rst_n = r; redir = rd; in_valid = iv; in_pc = pc; in_inst = inst; out_ready = ordy;
    #1;
    eval_model();
  endtask

  task automatic tick();
    logic enq, deq;
    if (!rst_n || redir) begin
      mq.delete();
    end else begin
      deq = exp_valid && out_ready && !exp_byp;
      enq = in_valid && exp_ready && !exp_byp;
      if (deq) void'(mq.pop_front());
      if (enq) mq.push_back({in_pc, in_inst});
    end
    @(posedge clk);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      apply(1'b0, 1'b0, 1'b1, 32'h40 + 32'(i), 32'h13, 1'b1);
      n_checks++;
      if (obs !== {2'b00, {(2*XLEN){1'b0}}, {CW{1'b0}}})
        $display("FAIL reset_hold: got %h exp 0", obs);
      else n_pass++;
      tick();
    end
    apply(1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
    n_checks++;
    if ({in_ready, out_valid, count} !== {1'b1, 1'b0, {CW{1'b0}}})
      $display("FAIL reset_release: got ready=%b valid=%b count=%0d exp ready=1 valid=0 count=0",
               in_ready, out_valid, count);
    else n_pass++;
    tick();
  endtask

  task automatic test_single_pass();
    apply(1'b1, 1'b0, 1'b1, 32'h100, 32'h00500093, 1'b1);
    n_checks++;
    if (obs !== exp_obs) $display("FAIL single_enq_cycle: got %h exp %h", obs, exp_obs);
    else n_pass++;
    tick();
    apply(1'b1, 1'b0, 1'b0, '0, '0, 1'b1);
    n_checks++;
    if ({out_valid, out_pc, out_inst} !== {!BYP, BYP ? 32'h0 : 32'h100, BYP ? 32'h0 : 32'h00500093})
      $display("FAIL single_out: got valid=%b pc=%h inst=%h exp valid=%b", out_valid, out_pc, out_inst, !BYP);
    else n_pass++;
    tick();
    apply(1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
    n_checks++;
    if (count !== '0) $display("FAIL single_count: got %0d exp 0", count);
    else n_pass++;
    tick();
  endtask

  task automatic test_fill_full();
    for (int k = 0; k < 4; k++) begin
      apply(1'b1, 1'b0, 1'b1, 32'(4*k), 32'hA000 + 32'(k), 1'b0);
      n_checks++;
      if (obs !== exp_obs) $display("FAIL fill_%0d: got %h exp %h", k, obs, exp_obs);
      else n_pass++;
      tick();
    end
    apply(1'b1, 1'b0, 1'b1, 32'h10, 32'hA004, 1'b0);
    n_checks++;
    if ({in_ready, count} !== {1'b0, CW'(4)})
      $display("FAIL full_state: got ready=%b count=%0d exp ready=0 count=4", in_ready, count);
    else n_pass++;
    tick();
    for (int k = 0; k < 4; k++) begin
      apply(1'b1, 1'b0, 1'b0, '0, '0, 1'b1);
      n_checks++;
      if ({out_valid, out_pc} !== {1'b1, 32'(4*k)})
        $display("FAIL drain_%0d: got valid=%b pc=%h exp valid=1 pc=%h", k, out_valid, out_pc, 4*k);
      else n_pass++;
      tick();
    end
    apply(1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
    n_checks++;
    if ({out_valid, count} !== {1'b0, CW'(0)})
      $display("FAIL drain_empty: got valid=%b count=%0d exp valid=0 count=0", out_valid, count);
    else n_pass++;
    tick();
  endtask

  task automatic test_wrap();
    int sent = 0, got = 0;
    for (int cyc = 0; cyc < 100 && got < 10; cyc++) begin
      apply(1'b1, 1'b0, sent < 10, 32'h200 + 32'(4*sent), 32'hB000 + 32'(sent), cyc[0]);
      n_checks++;
      if (obs !== exp_obs) $display("FAIL wrap_cycle_%0d: got %h exp %h", cyc, obs, exp_obs);
      else n_pass++;
      if (out_valid && out_ready) begin
        n_checks++;
        if (out_pc !== 32'h200 + 32'(4*got))
          $display("FAIL wrap_order_%0d: got pc=%h exp pc=%h", got, out_pc, 32'h200 + 32'(4*got));
        else n_pass++;
        got++;
      end
      if (in_valid && in_ready) sent++;
      tick();
    end
    n_checks++;
    if (got !== 10) $display("FAIL wrap_total: got %0d entries exp 10", got);
    else n_pass++;
  endtask

  task automatic test_flush();
    for (int k = 0; k < 3; k++) begin
      apply(1'b1, 1'b0, 1'b1, 32'h500 + 32'(4*k), 32'hC000 + 32'(k), 1'b0);
      tick();
    end
    apply(1'b1, 1'b1, 1'b1, 32'h700, 32'hC0DE, 1'b1);
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL flush_valid: got %b exp 0", out_valid);
    else n_pass++;
    tick();
    apply(1'b1, 1'b0, 1'b1, 32'h800, 32'hD00D, 1'b0);
    n_checks++;
    if ({count, out_valid} !== {CW'(0), 1'b0})
      $display("FAIL flush_count: got count=%0d valid=%b exp count=0 valid=0", count, out_valid);
    else n_pass++;
    tick();
    apply(1'b1, 1'b0, 1'b0, '0, '0, 1'b1);
    n_checks++;
    if ({out_valid, out_pc, out_inst} !== {1'b1, 32'h800, 32'hD00D})
      $display("FAIL flush_next: got valid=%b pc=%h inst=%h exp valid=1 pc=800 inst=d00d",
               out_valid, out_pc, out_inst);
    else n_pass++;
    tick();
  endtask

  task automatic test_simultaneous();
    for (int k = 0; k < 2; k++) begin
      apply(1'b1, 1'b0, 1'b1, 32'h300 + 32'(4*k), 32'hE000 + 32'(k), 1'b0);
      tick();
    end
    apply(1'b1, 1'b0, 1'b1, 32'h308, 32'hE002, 1'b1);
    n_checks++;
    if ({count, out_pc} !== {CW'(2), 32'h300})
      $display("FAIL simul_before: got count=%0d pc=%h exp count=2 pc=300", count, out_pc);
    else n_pass++;
    tick();
    apply(1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
    n_checks++;
    if ({count, out_pc} !== {CW'(2), 32'h304})
      $display("FAIL simul_after: got count=%0d pc=%h exp count=2 pc=304", count, out_pc);
    else n_pass++;
    tick();
    for (int k = 3; k < 5; k++) begin
      apply(1'b1, 1'b0, 1'b1, 32'h300 + 32'(4*k), 32'hE000 + 32'(k), 1'b0);
      tick();
    end
    apply(1'b1, 1'b0, 1'b1, 32'h314, 32'hE005, 1'b1);
    n_checks++;
    if ({in_ready, count} !== {1'b0, CW'(DEPTH)})
      $display("FAIL simul_full: got ready=%b count=%0d exp ready=0 count=%0d", in_ready, count, DEPTH);
    else n_pass++;
    tick();
    apply(1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
    n_checks++;
    if ({count, out_pc} !== {CW'(DEPTH-1), 32'h308})
      $display("FAIL simul_full_after: got count=%0d pc=%h exp count=%0d pc=308", count, out_pc, DEPTH-1);
    else n_pass++;
    tick();
    apply(1'b1, 1'b1, 1'b0, '0, '0, 1'b0);
    tick();
  endtask

  task automatic test_random();
    int bad = 0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      apply(($urandom_range(63) != 0), ($urandom_range(15) == 0), $urandom_range(1) == 1,
            $urandom, $urandom, $urandom_range(1) == 1);
      n_checks++;
      if (obs !== exp_obs) begin
        if (bad < 10)
          $display("FAIL random_cycle_%0d: got %h exp %h", cyc, obs, exp_obs);
        bad++;
      end else n_pass++;
      tick();
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_single_pass();
    test_fill_full();
    test_wrap();
    test_flush();
    test_simultaneous();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
